regfile_wb_scheduler: RTL
=========================

# regfile_wb_scheduler

Write-port scheduler and busy scoreboard in front of the 32x64 integer register file. It shares the file's single write port between NREQ writeback requesters (ALU, load unit, ecall/CSR path, …) using round-robin arbitration. It drives the registered `wb_en`/`wb_addr`/`wb_data` into the file. It tracks which architectural registers have an in-flight producer so decode can stall on RAW hazards.

## Interface
Parameters:
- `NREQ`, 3, number of writeback requesters (2..8)
- `XLEN`, 64, data width

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `req_valid`  in  NREQ  requester i has a write pending
- `req_addr`  in  NREQ*5  destination register of requester i (slice [5i+4:5i])
- `req_data`  in  NREQ*XLEN  write data of requester i (slice [XLEN*i+XLEN-1:XLEN*i])
- `req_ready`  out  NREQ  one-hot grant; transfer on `req_valid[i] & req_ready[i]`
- `wb_en`  out  1  register-file write enable (registered)
- `wb_addr`  out  5  register-file write address (registered)
- `wb_data`  out  XLEN  register-file write data (registered)
- `issue_valid`  in  1  decode issued an instruction writing `issue_rd`
- `issue_rd`  in  5  destination register to mark busy
- `query_rs1`, `query_rs2`  in  5 each  source registers being decoded
- `rs1_busy`, `rs2_busy`  out  1 each  combinational busy lookup
- `busy_vec`  out  32  full scoreboard, bit n = register n busy

## Operation
- Arbitration:
  - Round-robin pointer `ptr` (range 0..NREQ-1).
  - Grant the first `i` with `req_valid[i]`, searching `ptr, ptr+1, …` mod NREQ.
  - `req_ready` is combinational from `req_valid` and `ptr`.
  - At most one bit is set. It is all-zero when no request is pending, and all-zero while `reset` is high.
- Pointer update:
  - On a grant to `g`, `ptr <= (g+1) mod NREQ`.
  - With no grant, `ptr` holds.
- Write launch: on a handshake, next edge `wb_en <= (req_addr[g] != 0)`, `wb_addr <= req_addr[g]`, `wb_data <= req_data[g]`.
  - With no handshake, `wb_en <= 0` and `wb_addr`/`wb_data` hold.
  - Writes to x0 are accepted (handshake completes) but never produce `wb_en`.
- Scoreboard: 32 busy bits; bit 0 is hard-wired 0.
  - Set: `issue_valid & issue_rd != 0` sets `busy[issue_rd]` at the edge.
  - Clear: `wb_en` high clears `busy[wb_addr]` at the edge, i.e. the same edge at which the file commits the write.
  - Simultaneous set and clear of the same register: set wins (a newer producer is in flight).
  - Set and clear of different registers in one cycle: both take effect.
- Lookup: `rsN_busy = busy[query_rsN]`; query of x0 returns 0.
  - The lookup does not see same-cycle `issue_valid` or the same-cycle clear. Both are visible the cycle after.
- Only one outstanding producer per register is tracked. Decode must stall issue to a busy `rd` (WAW); the block does not check this.

## Timing
- Reset values, applied asynchronously while `reset` is high:
  - `ptr=0`, `busy=0`, `busy_vec=0`
  - `wb_en=0`, `wb_addr=0`, `wb_data=0`
  - `req_ready=0`, `rs1_busy=rs2_busy=0`
- Reset mid-operation: a transfer accepted in the cycle before reset asserts is dropped (no `wb_en`), and its busy bit is lost.
- First grant is possible in the first cycle after reset deasserts.
- Latency: handshake in cycle N, then `wb_en` high in cycle N+1, then the file is written and the busy bit cleared at the end of N+1. A dependent `rsN_busy` reads 0 from cycle N+2.
- Throughput: one write per cycle. A requester held valid alone is granted every cycle.
- With K requesters continuously valid, each is granted exactly once per K cycles.
- Requesters must hold `req_valid`/`req_addr`/`req_data` stable until granted. The block does not store ungranted requests.

## Test plan
- Reset:
  - Assert `reset` asynchronously mid-cycle with `busy[5]=1` and `wb_en=1`.
  - Required: all outputs go to 0 before the next edge, `busy_vec=0`, and no write is issued after release.
- Single write:
  - Cycle 0: `issue_valid=1, issue_rd=7`.
  - Cycle 2: requester 1 offers `addr=7, data=0xDEAD_BEEF`.
  - Required: `req_ready=3'b010` in cycle 2; cycle 3 `wb_en=1, wb_addr=7, wb_data=0xDEAD_BEEF`; `busy[7]` reads 1 through cycle 3 and 0 in cycle 4.
- Round-robin:
  - All 3 requesters valid for 6 cycles from reset.
  - Required: grant sequence 0,1,2,0,1,2.
  - Drop requester 1 after its first grant: sequence becomes 0,1,2,0,2,0.
- x0 write: requester 0 writes `addr=0, data=0x55`.
  - Required: `req_ready[0]=1`, `wb_en` stays 0, and `busy_vec` stays 0.
- Set/clear collision:
  - `busy[9]=1`, write to x9 in flight.
  - In the `wb_en` cycle for x9, also drive `issue_valid=1, issue_rd=9`.
  - Required: `busy[9]` remains 1 afterwards.
- Concurrent different registers:
  - Issue `rd=3` in the same cycle as `wb_en` for x4.
  - Required next cycle: `busy[3]=1` and `busy[4]=0`.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the register file's single write port, plus a
// busy scoreboard that decode uses to stall on RAW hazards.
module regfile_wb_scheduler #(
    parameter int NREQ = 3,
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wb_en,
    output logic [4:0]           wb_addr,
    output logic [XLEN-1:0]      wb_data,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [4:0]           query_rs1,
    input  logic [4:0]           query_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [31:0]          busy_vec
);

    localparam int          PW = $clog2(NREQ);
    localparam int unsigned N  = NREQ;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic            fire;
    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

    // Search ptr, ptr+1, ... (mod NREQ) for the first valid requester.
    always_comb begin
        int unsigned idx;
        idx  = 0;
        fire = 1'b0;
        gidx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!fire && req_valid[PW'(idx)]) begin
                fire = 1'b1;
                gidx = PW'(idx);
            end
        end
        if (reset) fire = 1'b0;
        req_ready = fire ? (NREQ'(1) << gidx) : '0;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (PW'(i) == gidx) begin
                sel_addr = req_addr[5*i +: 5];
                sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= fire && (sel_addr != 5'd0);
            if (fire) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
                ptr     <= (32'(gidx) == N - 1) ? '0 : gidx + PW'(1);
            end
        end
    end

    // Clear is applied before set so a new producer issued on the commit
    // edge of the previous one keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_en) busy_nxt[wb_addr] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    assign busy_vec = busy;
    assign rs1_busy = busy[query_rs1];
    assign rs2_busy = busy[query_rs2];

endmodule
